// File: rtl/beam_power_acc_pkg.sv
// Shared types and default sizing for the beam power accumulator.
package beam_power_acc_pkg;

    localparam int unsigned BEAM_DEFAULT  = 16;
    localparam int unsigned OW_DEFAULT    = 48;
    localparam int unsigned AW_DEFAULT    = 40;
    localparam int unsigned SHIFT_DEFAULT = 16;
    localparam int unsigned DW_DEFAULT    = 16;

    // Dump-side state; an open packet is tracked separately so ACC and DUMP can overlap.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DUMP = 2'd2
    } dump_state_e;

endpackage

// File: rtl/beam_pwr_lane.sv
// One beam lane: shift/saturate, power, saturating accumulate.
module beam_pwr_lane
    import beam_power_acc_pkg::*;
#(
    parameter int unsigned OW    = OW_DEFAULT,
    parameter int unsigned SHIFT = SHIFT_DEFAULT,
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned AW    = AW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [OW-1:0] in_i_i,
    input  logic [OW-1:0] in_q_i,
    input  logic          acc_en_i,
    input  logic          acc_load_i,
    output logic [AW-1:0] acc_nxt_c
);

    localparam int unsigned PW = 2 * DW;
    localparam int unsigned SW = AW + 1;
    localparam logic signed [DW-1:0] SAT_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_NEG = {1'b1, {(DW-2){1'b0}}, 1'b1};

    logic signed [DW-1:0] s1_i_d, s1_i_q;
    logic signed [DW-1:0] s1_q_d, s1_q_q;
    logic signed [PW-1:0] sq_i, sq_q;
    logic [PW-1:0]        pwr_d, pwr_q;
    logic [SW-1:0]        sum;
    logic [AW-1:0]        acc_sat;
    logic [AW-1:0]        acc_d, acc_q;

    // Arithmetic shift then clamp to the symmetric range +/-(2^(DW-1)-1).
    function automatic logic signed [DW-1:0] sat_shift(input logic [OW-1:0] x);
        logic signed [OW-1:0] sh;
        logic [OW-DW:0]       hi;
        sh = $signed(x) >>> SHIFT;
        hi = sh[OW-1:DW-1];
        if (hi == '0) begin
            return sh[DW-1:0];
        end else if (&hi) begin
            return (sh[DW-2:0] == '0) ? SAT_NEG : sh[DW-1:0];
        end else begin
            return sh[OW-1] ? SAT_NEG : SAT_POS;
        end
    endfunction

    // Stage-1 and stage-2 next values.
    always_comb begin
        s1_i_d = sat_shift(in_i_i);
        s1_q_d = sat_shift(in_q_i);
        sq_i   = PW'(s1_i_q) * PW'(s1_i_q);
        sq_q   = PW'(s1_q_q) * PW'(s1_q_q);
        pwr_d  = $unsigned(sq_i + sq_q);
    end

    // Saturating accumulate; sop reloads with the current sample power.
    always_comb begin
        sum     = {1'b0, acc_q} + SW'(pwr_q);
        acc_sat = sum[AW] ? '1 : sum[AW-1:0];
        acc_d   = acc_q;
        if (acc_en_i) begin
            acc_d = acc_load_i ? AW'(pwr_q) : acc_sat;
        end
    end

    assign acc_nxt_c = acc_d;

    // Pipeline and accumulator registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_i_q <= '0;
            s1_q_q <= '0;
            pwr_q  <= '0;
            acc_q  <= '0;
        end else begin
            s1_i_q <= s1_i_d;
            s1_q_q <= s1_q_d;
            pwr_q  <= pwr_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/beam_power_acc.sv
// Per-beam power accumulation with snapshot dump and strongest-beam search.
module beam_power_acc
    import beam_power_acc_pkg::*;
#(
    parameter int unsigned BEAM  = BEAM_DEFAULT,
    parameter int unsigned OW    = OW_DEFAULT,
    parameter int unsigned SHIFT = SHIFT_DEFAULT,
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned AW    = AW_DEFAULT
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [BEAM-1:0][OW-1:0]        i_data_i,
    input  logic [BEAM-1:0][OW-1:0]        i_data_q,
    input  logic                           i_tvalid,
    input  logic                           i_sop,
    input  logic                           i_eop,
    output logic [AW-1:0]                  o_pwr,
    output logic [$clog2(BEAM)-1:0]        o_beam_idx,
    output logic                           o_pwr_valid,
    output logic                           o_pwr_sop,
    output logic                           o_pwr_eop,
    output logic [$clog2(BEAM)-1:0]        o_max_idx,
    output logic [AW-1:0]                  o_max_pwr,
    output logic                           o_overrun
);

    localparam int unsigned IW = $clog2(BEAM);

    // Control pipeline aligned with lane stages 1 and 2.
    logic v1_q, sop1_q, eop1_q;
    logic v2_q, sop2_q, eop2_q;

    logic [AW-1:0] acc_nxt [BEAM];
    logic [AW-1:0] snap_q  [BEAM];

    dump_state_e   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          pkt_open_q, pkt_open_d;
    logic          eop_acc, dump_last, snap_take, overrun_c;

    logic [AW-1:0] pwr_d, run_pwr_q, run_pwr_d, cand_pwr, max_pwr_d;
    logic [IW-1:0] beam_idx_d, run_idx_q, run_idx_d, cand_idx, max_idx_d;
    logic          pwr_valid_d, sop_d, eop_d;

    for (genvar b = 0; b < BEAM; b++) begin : g_lane
        beam_pwr_lane #(
            .OW    (OW),
            .SHIFT (SHIFT),
            .DW    (DW),
            .AW    (AW)
        ) u_lane (
            .clk_i      (i_clk),
            .rst_i      (i_reset),
            .in_i_i     (i_data_i[b]),
            .in_q_i     (i_data_q[b]),
            .acc_en_i   (v2_q),
            .acc_load_i (sop2_q),
            .acc_nxt_c  (acc_nxt[b])
        );
    end

    // Sample qualifier pipeline; delimiters only count with tvalid.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            v1_q   <= 1'b0;
            sop1_q <= 1'b0;
            eop1_q <= 1'b0;
            v2_q   <= 1'b0;
            sop2_q <= 1'b0;
            eop2_q <= 1'b0;
        end else begin
            v1_q   <= i_tvalid;
            sop1_q <= i_tvalid & i_sop;
            eop1_q <= i_tvalid & i_eop;
            v2_q   <= v1_q;
            sop2_q <= sop1_q;
            eop2_q <= eop1_q;
        end
    end

    // Packet tracking and snapshot acceptance / overrun decisions.
    always_comb begin
        eop_acc    = v2_q & eop2_q & (pkt_open_q | sop2_q);
        dump_last  = (state_q == ST_DUMP) && (idx_q == IW'(BEAM - 1));
        snap_take  = eop_acc && ((state_q != ST_DUMP) || dump_last);
        overrun_c  = eop_acc && (state_q == ST_DUMP) && !dump_last;
        pkt_open_d = pkt_open_q;
        if (v2_q) begin
            if (eop2_q) begin
                pkt_open_d = 1'b0;
            end else if (sop2_q) begin
                pkt_open_d = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and dump index.
    always_comb begin
        state_d = state_q;
        idx_d   = '0;
        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (snap_take) begin
                    state_d = ST_DUMP;
                end else begin
                    state_d = pkt_open_d ? ST_ACC : ST_IDLE;
                end
            end
            ST_DUMP: begin
                if (!dump_last) begin
                    idx_d = idx_q + IW'(1);
                end else if (snap_take) begin
                    state_d = ST_DUMP;
                end else begin
                    state_d = pkt_open_d ? ST_ACC : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Dump outputs and running maximum (strict compare keeps the lowest index on ties).
    always_comb begin
        pwr_d       = '0;
        beam_idx_d  = '0;
        pwr_valid_d = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        cand_pwr    = run_pwr_q;
        cand_idx    = run_idx_q;
        run_pwr_d   = run_pwr_q;
        run_idx_d   = run_idx_q;
        max_pwr_d   = o_max_pwr;
        max_idx_d   = o_max_idx;
        if (state_q == ST_DUMP) begin
            pwr_valid_d = 1'b1;
            pwr_d       = snap_q[idx_q];
            beam_idx_d  = idx_q;
            sop_d       = (idx_q == '0);
            eop_d       = dump_last;
            if ((idx_q == '0) || (snap_q[idx_q] > run_pwr_q)) begin
                cand_pwr = snap_q[idx_q];
                cand_idx = idx_q;
            end
            run_pwr_d = cand_pwr;
            run_idx_d = cand_idx;
            if (dump_last) begin
                max_pwr_d = cand_pwr;
                max_idx_d = cand_idx;
            end
        end
    end

    // Datapath registers: snapshot, index, packet flag, outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int b = 0; b < BEAM; b++) begin
                snap_q[b] <= '0;
            end
            idx_q       <= '0;
            pkt_open_q  <= 1'b0;
            run_pwr_q   <= '0;
            run_idx_q   <= '0;
            o_pwr       <= '0;
            o_beam_idx  <= '0;
            o_pwr_valid <= 1'b0;
            o_pwr_sop   <= 1'b0;
            o_pwr_eop   <= 1'b0;
            o_max_idx   <= '0;
            o_max_pwr   <= '0;
            o_overrun   <= 1'b0;
        end else begin
            if (snap_take) begin
                for (int b = 0; b < BEAM; b++) begin
                    snap_q[b] <= acc_nxt[b];
                end
            end
            idx_q       <= idx_d;
            pkt_open_q  <= pkt_open_d;
            run_pwr_q   <= run_pwr_d;
            run_idx_q   <= run_idx_d;
            o_pwr       <= pwr_d;
            o_beam_idx  <= beam_idx_d;
            o_pwr_valid <= pwr_valid_d;
            o_pwr_sop   <= sop_d;
            o_pwr_eop   <= eop_d;
            o_max_idx   <= max_idx_d;
            o_max_pwr   <= max_pwr_d;
            o_overrun   <= overrun_c;
        end
    end

endmodule

// File: tb/tb_beam_power_acc.sv
// Scoreboard bench for beam_power_acc: directed packets, monitor checks dumps.
module tb_beam_power_acc;

    localparam int BEAM = 16;
    localparam int OW   = 48;
    localparam int AW   = 40;
    localparam int IW   = 4;

    logic                    i_clk = 1'b0;
    logic                    i_reset;
    logic [BEAM-1:0][OW-1:0] i_data_i;
    logic [BEAM-1:0][OW-1:0] i_data_q;
    logic                    i_tvalid, i_sop, i_eop;
    logic [AW-1:0]           o_pwr;
    logic [IW-1:0]           o_beam_idx;
    logic                    o_pwr_valid, o_pwr_sop, o_pwr_eop;
    logic [IW-1:0]           o_max_idx;
    logic [AW-1:0]           o_max_pwr;
    logic                    o_overrun;

    beam_power_acc dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_data_i    (i_data_i),
        .i_data_q    (i_data_q),
        .i_tvalid    (i_tvalid),
        .i_sop       (i_sop),
        .i_eop       (i_eop),
        .o_pwr       (o_pwr),
        .o_beam_idx  (o_beam_idx),
        .o_pwr_valid (o_pwr_valid),
        .o_pwr_sop   (o_pwr_sop),
        .o_pwr_eop   (o_pwr_eop),
        .o_max_idx   (o_max_idx),
        .o_max_pwr   (o_max_pwr),
        .o_overrun   (o_overrun)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct {
        logic [AW-1:0] pwr;
        int            idx;
        logic          sop;
        logic          eop;
        int            cyc;
        int            midx;
        logic [AW-1:0] mpwr;
    } exp_t;

    exp_t          sb[$];
    int            ovr_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [AW-1:0] exp_pwr [BEAM];
    logic [OW-1:0] di [BEAM];
    logic [OW-1:0] dq [BEAM];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Queue the expected dump for a packet whose input eop was in cycle c.
    task automatic push_dump(input int c, input int n);
        exp_t e;
        int   mi;
        logic [AW-1:0] mp;
        mi = 0;
        mp = exp_pwr[0];
        for (int k = 1; k < BEAM; k++) begin
            if (exp_pwr[k] > mp) begin
                mp = exp_pwr[k];
                mi = k;
            end
        end
        for (int k = 0; k < n; k++) begin
            e.pwr  = exp_pwr[k];
            e.idx  = k;
            e.sop  = (k == 0);
            e.eop  = (k == BEAM - 1);
            e.cyc  = c + 4 + k;
            e.midx = mi;
            e.mpwr = mp;
            sb.push_back(e);
        end
    endtask

    task automatic beat(input logic v, input logic s, input logic e, output int c);
        @(negedge i_clk);
        i_tvalid = v;
        i_sop    = s;
        i_eop    = e;
        for (int k = 0; k < BEAM; k++) begin
            i_data_i[k] = di[k];
            i_data_q[k] = dq[k];
        end
        c = cyc;
    endtask

    task automatic idle(input int n);
        int c;
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, c);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"},   64'(o_pwr_valid), 64'd0);
        chk({tag, "_pwr"},     64'(o_pwr),       64'd0);
        chk({tag, "_idx"},     64'(o_beam_idx),  64'd0);
        chk({tag, "_sop"},     64'(o_pwr_sop),   64'd0);
        chk({tag, "_eop"},     64'(o_pwr_eop),   64'd0);
        chk({tag, "_max_idx"}, 64'(o_max_idx),   64'd0);
        chk({tag, "_max_pwr"}, 64'(o_max_pwr),   64'd0);
        chk({tag, "_overrun"}, 64'(o_overrun),   64'd0);
    endtask

    // Monitor: every dump beat and overrun pulse must match a queued expectation.
    always @(negedge i_clk) begin
        if (o_pwr_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pwr_valid: beam %0d pwr %0d at cycle %0d, none expected",
                         o_beam_idx, o_pwr, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("pwr",      64'(o_pwr),      64'(mon_e.pwr));
                chk("beam_idx", 64'(o_beam_idx), 64'(mon_e.idx));
                chk("pwr_cyc",  64'(cyc),        64'(mon_e.cyc));
                chk("pwr_sop",  64'(o_pwr_sop),  64'(mon_e.sop));
                chk("pwr_eop",  64'(o_pwr_eop),  64'(mon_e.eop));
                if (mon_e.eop) begin
                    chk("max_idx", 64'(o_max_idx), 64'(mon_e.midx));
                    chk("max_pwr", 64'(o_max_pwr), 64'(mon_e.mpwr));
                end
            end
        end
        if (o_overrun === 1'b1) begin
            if (ovr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_overrun: pulse at cycle %0d, none expected", cyc);
            end else begin
                chk("overrun_cyc", 64'(cyc), 64'(ovr_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d expected below 20000", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c, cA, cD, cF;
        i_reset  = 1'b1;
        i_tvalid = 1'b0;
        i_sop    = 1'b0;
        i_eop    = 1'b0;
        i_data_i = '0;
        i_data_q = '0;
        for (int k = 0; k < BEAM; k++) begin
            di[k] = '0;
            dq[k] = '0;
        end
        repeat (3) @(negedge i_clk);
        chk_zero_outputs("reset");
        i_reset = 1'b0;
        idle(3);

        // 4-sample packet, beam k I=(k+1)<<16: power 4*(k+1)^2.
        for (int k = 0; k < BEAM; k++) begin
            di[k] = OW'(longint'(k + 1) << 16);
            dq[k] = '0;
            exp_pwr[k] = AW'(longint'(4 * (k + 1) * (k + 1)));
        end
        beat(1'b1, 1'b1, 1'b0, c);
        beat(1'b1, 1'b0, 1'b0, c);
        beat(1'b1, 1'b0, 1'b0, c);
        beat(1'b1, 1'b0, 1'b1, c);
        push_dump(c, BEAM);
        idle(25);

        // Full-scale one-sample packet, positive and negative extremes saturate to 32767.
        for (int k = 0; k < BEAM; k++) begin
            di[k] = (k % 2 == 0) ? {1'b0, {(OW-1){1'b1}}} : {1'b1, {(OW-1){1'b0}}};
            dq[k] = di[k];
            exp_pwr[k] = AW'(64'd2147352578);
        end
        beat(1'b1, 1'b1, 1'b1, c);
        push_dump(c, BEAM);
        idle(25);

        // 513 full-scale samples overflow 2^40 and must clamp.
        beat(1'b1, 1'b1, 1'b0, c);
        for (int i = 0; i < 511; i++) begin
            beat(1'b1, 1'b0, 1'b0, c);
            if (i == 200) beat(1'b0, 1'b0, 1'b0, c);
        end
        beat(1'b1, 1'b0, 1'b1, c);
        for (int k = 0; k < BEAM; k++) exp_pwr[k] = '1;
        push_dump(c, BEAM);
        idle(25);

        // One-sample sop+eop packet surrounded by invalid cycles carrying delimiters.
        for (int k = 0; k < BEAM; k++) begin
            di[k] = OW'(longint'(5) << 16);
            dq[k] = di[k];
        end
        beat(1'b0, 1'b1, 1'b1, c);
        beat(1'b0, 1'b1, 1'b0, c);
        for (int k = 0; k < BEAM; k++) begin
            di[k] = OW'(longint'(1) << 16);
            dq[k] = di[k];
            exp_pwr[k] = AW'(64'd2);
        end
        beat(1'b1, 1'b1, 1'b1, c);
        push_dump(c, BEAM);
        for (int k = 0; k < BEAM; k++) begin
            di[k] = OW'(longint'(7) << 16);
            dq[k] = di[k];
        end
        beat(1'b0, 1'b0, 1'b1, c);
        idle(25);

        // Restart on sop without a prior eop: only the last 3 samples count.
        for (int k = 0; k < BEAM; k++) begin
            di[k] = OW'(longint'(100) << 16);
            dq[k] = '0;
        end
        beat(1'b1, 1'b1, 1'b0, c);
        beat(1'b1, 1'b0, 1'b0, c);
        beat(1'b1, 1'b0, 1'b0, c);
        for (int k = 0; k < BEAM; k++) begin
            di[k] = OW'(longint'(k + 1) << 16);
            dq[k] = OW'(longint'(2) << 16);
            exp_pwr[k] = AW'(longint'(3 * ((k + 1) * (k + 1) + 4)));
        end
        beat(1'b1, 1'b1, 1'b0, c);
        beat(1'b1, 1'b0, 1'b0, c);
        beat(1'b1, 1'b0, 1'b1, c);
        push_dump(c, BEAM);
        idle(25);

        // Second eop lands 5 cycles into the first dump: overrun, first dump intact.
        for (int k = 0; k < BEAM; k++) begin
            di[k] = OW'(longint'(k + 1) << 16);
            dq[k] = di[k];
            exp_pwr[k] = AW'(longint'(4 * (k + 1) * (k + 1)));
        end
        beat(1'b1, 1'b1, 1'b0, c);
        beat(1'b1, 1'b0, 1'b1, cA);
        push_dump(cA, BEAM);
        for (int k = 0; k < BEAM; k++) begin
            di[k] = OW'(longint'(k + 7) << 16);
            dq[k] = '0;
        end
        beat(1'b1, 1'b1, 1'b0, c);
        beat(1'b1, 1'b0, 1'b0, c);
        beat(1'b1, 1'b0, 1'b0, c);
        beat(1'b1, 1'b0, 1'b0, c);
        beat(1'b1, 1'b0, 1'b1, c);
        ovr_q.push_back(c + 3);
        idle(25);

        // Eop whose delayed copy coincides with the last dump beat is accepted.
        for (int k = 0; k < BEAM; k++) begin
            di[k] = OW'(longint'(k + 1) << 16);
            dq[k] = '0;
            exp_pwr[k] = AW'(longint'((k + 1) * (k + 1)));
        end
        beat(1'b1, 1'b1, 1'b1, cD);
        push_dump(cD, BEAM);
        idle(15);
        for (int k = 0; k < BEAM; k++) begin
            di[k] = OW'(longint'(3) << 16);
            exp_pwr[k] = AW'(64'd9);
        end
        beat(1'b1, 1'b1, 1'b1, c);
        push_dump(c, BEAM);
        idle(4);
        chk("max_hold_idx", 64'(o_max_idx), 64'd15);
        chk("max_hold_pwr", 64'(o_max_pwr), 64'd256);
        idle(25);

        // Eop with no open packet is ignored.
        beat(1'b1, 1'b0, 1'b1, c);
        idle(25);

        // Reset while beam 7 of a dump is on the output.
        for (int k = 0; k < BEAM; k++) begin
            di[k] = OW'(longint'(k + 1) << 16);
            dq[k] = '0;
            exp_pwr[k] = AW'(longint'((k + 1) * (k + 1)));
        end
        beat(1'b1, 1'b1, 1'b1, cF);
        push_dump(cF, 8);
        idle(11);
        i_reset = 1'b1;
        chk("rst_beam7_valid", 64'(o_pwr_valid), 64'd1);
        chk("rst_beam7_idx",   64'(o_beam_idx),  64'd7);
        beat(1'b0, 1'b0, 1'b0, c);
        chk_zero_outputs("midrst");
        beat(1'b1, 1'b1, 1'b1, c);
        beat(1'b1, 1'b1, 1'b1, c);
        beat(1'b0, 1'b0, 1'b0, c);
        i_reset = 1'b0;
        idle(30);
        chk_zero_outputs("postrst");

        chk("sb_empty",  64'(sb.size()),    64'd0);
        chk("ovr_empty", 64'(ovr_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/beam_power_acc.md
BEAM_POWER_ACC -- requirements
Module: beam_power_acc

Interface
REQ-001 SHALL have parameter BEAM, default 16, number of beams.
REQ-002 SHALL have parameter OW, default 48, input I/Q width per beam (signed).
REQ-003 SHALL have parameter SHIFT, default 16, arithmetic right shift applied to inputs before saturation.
REQ-004 SHALL have parameter DW, default 16, signed width after shift/saturate.
REQ-005 SHALL have parameter AW, default 40, unsigned power accumulator width.
REQ-006 SHALL have port i_clk, input, 1, sole clock; all logic rising-edge.
REQ-007 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports i_data_i / i_data_q, input, [BEAM-1:0][OW-1:0], beam-combined I/Q from the beam MAC stage.
REQ-009 SHALL have ports i_tvalid / i_sop / i_eop, input, 1 each, sample qualifier and packet delimiters; sop/eop meaningful only with i_tvalid.
REQ-010 SHALL have port o_pwr, output, AW, accumulated power of one beam.
REQ-011 SHALL have port o_beam_idx, output, $clog2(BEAM), beam index of o_pwr.
REQ-012 SHALL have ports o_pwr_valid / o_pwr_sop / o_pwr_eop, output, 1 each, dump qualifier, first-beam and last-beam markers.
REQ-013 SHALL have ports o_max_idx (output, $clog2(BEAM)) and o_max_pwr (output, AW), strongest beam, valid with o_pwr_eop.
REQ-014 SHALL have port o_overrun, output, 1, one-cycle pulse when a completed packet is dropped.

Function
REQ-015 Stage 1 (registered): per beam, I and Q arithmetic-shifted right by SHIFT, then saturated to [-2^(DW-1)+1, 2^(DW-1)-1] (symmetric).
REQ-016 Stage 2 (registered): per beam, p = I^2 + Q^2, unsigned 2*DW bits.
REQ-017 Stage 3: per beam accumulator acc += p on every delayed valid sample; acc saturates at 2^AW-1, never wraps.
REQ-018 Delayed sop SHALL load acc = p (clears prior content, including an unterminated packet); delayed valid without sop adds.
REQ-019 i_tvalid low cycles SHALL not change any accumulator; sop and eop on the same valid cycle form a one-sample packet.
REQ-020 States: IDLE (no packet), ACC (packet open), DUMP (serialising snapshot); ACC and DUMP may coexist via separate snapshot buffer (state field tracks dump; packet-open flag tracks ACC).
REQ-021 On delayed eop, final acc values (including the eop sample) SHALL be copied to a snapshot buffer and dump started.
REQ-022 Latency: first o_pwr_valid SHALL assert exactly 4 cycles after the input eop cycle; beams output in order 0..BEAM-1 on BEAM consecutive cycles, no gaps.
REQ-023 o_pwr_sop with beam 0, o_pwr_eop with beam BEAM-1; o_max_idx/o_max_pwr valid on the o_pwr_eop cycle, held until next dump ends.
REQ-024 Max tie-break: lowest beam index wins; all-zero powers give o_max_idx=0, o_max_pwr=0.
REQ-025 Delayed eop arriving while DUMP active SHALL drop the new snapshot, pulse o_overrun one cycle, and leave the current dump intact.
REQ-026 Delayed eop with dump completing that same cycle SHALL be accepted (no overrun); new dump starts next cycle.
REQ-027 Delayed eop without an open packet SHALL be ignored (no dump, no overrun).

Reset
REQ-028 i_reset SHALL clear pipeline valids, accumulators, snapshot, state to IDLE, and all outputs to 0, effective the cycle after assertion.
REQ-029 Reset mid-packet or mid-dump SHALL abort without any further o_pwr_valid; input eop within 3 cycles before reset release produces no dump.

Structure
REQ-030 Shared package SHALL hold the state enum (IDLE/ACC/DUMP) and default constants BEAM, OW, AW.
REQ-031 One sub-module beam_pwr_lane (stages 1-3 for one beam) SHALL be instantiated BEAM times; dump FSM and max search in top level.

Verification
REQ-032 Beam k I=(k+1)<<16, Q=0, 4-sample packet -> o_pwr=4*(k+1)^2 for beam k (beam 15: 1024), o_max_idx=15, first valid 4 cycles after eop.
REQ-033 All I=Q=2^47-1 for 1 sample -> each o_pwr=2*32767^2=2147352578; 2^20 samples with AW=40 -> o_pwr=2^40-1.
REQ-034 Two packets back-to-back, second eop arriving 5 cycles into dump -> o_overrun one pulse, first dump of 16 beams completes unchanged.
REQ-035 sop+eop same cycle, I=Q=1<<16 on all beams with tvalid gaps injected elsewhere -> o_pwr=2 all beams, o_max_idx=0.
REQ-036 Reset asserted on beam 7 of dump -> o_pwr_valid low from next cycle, no o_pwr_eop, outputs 0.
REQ-037 sop at sample 3 without prior eop, then 2 samples and eop -> powers reflect only the last 3 samples.
